// File: rtl/aes_192_req_sequencer.sv
// Sequences one AES-192 request at a time into the unrolled core. Accept-to-result is 29 cycles.
// A 1-deep holding register feeds the core, and a result register drains on res_valid/res_ready.
module aes_192_req_sequencer #(
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [191:0]     in_key,
  input  logic [ID_W-1:0]  in_id,
  output logic             aes_start,
  output logic [127:0]     aes_state,
  output logic [191:0]     aes_key,
  input  logic [127:0]     aes_out,
  input  logic             aes_out_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [127:0]     res_data,
  output logic [ID_W-1:0]  res_id,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [127:0]    state;
    logic [191:0]    key;
    logic [ID_W-1:0] id;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_next;
  req_t            hold;
  logic            hold_full;
  logic [ID_W-1:0] pend_id;
  logic [WC_W-1:0] wait_cnt;

  logic accept, issue_fire, capture, timeout_hit, res_hs;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hold_full && !res_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (capture)          state_next = DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      DONE:    if (res_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state action strobes
  always_comb begin
    accept      = in_valid && !hold_full;
    issue_fire  = (state == ISSUE);
    capture     = (state == WAIT) && aes_out_valid;
    timeout_hit = (state == WAIT) && !aes_out_valid &&
                  (wait_cnt == WC_W'(TIMEOUT - 1));
    res_hs      = (state == DONE) && res_ready;
  end

  assign in_ready  = !hold_full;
  assign aes_state = hold.state;
  assign aes_key   = hold.key;
  assign busy      = (state != IDLE) || hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      pend_id     <= '0;
      wait_cnt    <= '0;
      aes_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_id      <= '0;
      err_timeout <= 1'b0;
      done_cnt    <= '0;
    end else begin
      // Start is a flop so the core sees a clean one-cycle pulse aligned to ISSUE.
      aes_start <= (state_next == ISSUE);

      if (accept) begin
        hold      <= '{state: in_state, key: in_key, id: in_id};
        hold_full <= 1'b1;
      end else if (issue_fire) begin
        hold_full <= 1'b0;
      end

      if (issue_fire) begin
        pend_id  <= hold.id;
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (capture) begin
        res_data  <= aes_out;
        res_id    <= pend_id;
        res_valid <= 1'b1;
      end else if (res_hs) begin
        res_valid <= 1'b0;
        done_cnt  <= done_cnt + 1'b1;
      end

      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_192_req_sequencer.sv
// Directed bench for aes_192_req_sequencer with a behavioural model of the unrolled core.
module tb_aes_192_req_sequencer;

  localparam int TIMEOUT = 40;
  localparam logic [191:0] NIST_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] NIST_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NIST_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [191:0] in_key = '0;
  logic [3:0]   in_id = '0;
  logic         aes_start;
  logic [127:0] aes_state;
  logic [191:0] aes_key;
  logic [127:0] aes_out;
  logic         aes_out_valid;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic [3:0]   res_id;
  logic         busy;
  logic         err_timeout;
  logic [15:0]  done_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  aes_192_req_sequencer #(.ID_W(4), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_id(in_id),
    .aes_start(aes_start), .aes_state(aes_state), .aes_key(aes_key),
    .aes_out(aes_out), .aes_out_valid(aes_out_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .busy(busy), .err_timeout(err_timeout), .done_cnt(done_cnt)
  );

  // Core stand-in: NIST vector gives the real ciphertext, anything else a simple mix.
  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [191:0] key);
    if (pt == NIST_PT && key == NIST_KEY) return NIST_CT;
    return ~pt ^ key[127:0] ^ {key[191:128], key[191:128]};
  endfunction

  logic [127:0] core_ct;
  logic         core_ov;
  logic         core_run;
  int           core_cnt;
  bit           never_valid = 1'b0;

  // Counter reloads on the start edge, so out_valid stays high (stale) until the next job starts.
  always @(posedge clk) begin
    if (rst) begin
      core_ct <= '0; core_ov <= 1'b0; core_run <= 1'b0; core_cnt <= 0;
    end else if (aes_start) begin
      core_ct <= model_ct(aes_state, aes_key);
      core_ov <= 1'b0; core_run <= 1'b1; core_cnt <= 0;
    end else if (core_run) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 24 && !never_valid) begin
        core_ov <= 1'b1; core_run <= 1'b0;
      end
    end
  end
  assign aes_out       = core_ct;
  assign aes_out_valid = core_ov;

  int   n_starts = 0;
  int   bad_start = 0;
  logic start_q = 1'b0;
  always @(posedge clk) begin
    if (rst) start_q <= 1'b0;
    else begin
      if (aes_start && !start_q) n_starts++;
      if (aes_start && start_q)  bad_start++;
      start_q <= aes_start;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Returns in cycle 1 (accept edge ends cycle 0).
  task automatic send(input logic [127:0] pt, input logic [191:0] key, input logic [3:0] id);
    int g = 0;
    while (!in_ready && g < 300) begin step(); g++; end
    if (!in_ready) begin
      nchk++; nerr++;
      $display("FAIL send_wait: in_ready still %b after %0d cycles", in_ready, g);
    end
    in_valid = 1'b1; in_state = pt; in_key = key; in_id = id;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int c0, output int c);
    int g = 0;
    c = c0;
    while (!res_valid && g < 200) begin step(); c++; g++; end
    if (!res_valid) begin
      nchk++; nerr++;
      $display("FAIL wait_res: res_valid still %b after %0d cycles", res_valid, g);
    end
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [191:0] key;
    logic [3:0]   id;
    logic [127:0] exp_ct;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, nchk=%0d", nchk);
    $fatal(1, "timeout");
  end

  initial begin
    int c, s0, saw, got;
    logic [127:0] d;
    logic [3:0]   got_id[4];
    logic [127:0] got_dat[4];
    logic [127:0] sp[4];
    logic [191:0] sk[4];

    vecs[0] = '{NIST_PT, NIST_KEY, 4'd5, NIST_CT};
    vecs[1] = '{128'h0, 192'h0, 4'd0, 128'h0};
    vecs[2] = '{{128{1'b1}}, {192{1'b1}}, 4'd15, 128'h0};
    vecs[3] = '{128'h0123456789abcdeffedcba9876543210,
                192'hdeadbeef00112233445566778899aabbccddeeff01234567, 4'd10, 128'h0};
    for (int i = 1; i < 4; i++) vecs[i].exp_ct = model_ct(vecs[i].pt, vecs[i].key);

    do_reset();
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_aes_start", aes_start, 1'b0);
    check1("rst_res_valid", res_valid, 1'b0);
    checkv("rst_res_data", res_data, 128'h0);
    checkv("rst_res_id", 128'(res_id), 128'h0);
    check1("rst_err_timeout", err_timeout, 1'b0);
    checkv("rst_done_cnt", 128'(done_cnt), 128'h0);
    check1("rst_busy", busy, 1'b0);

    // Table-driven single requests with an always-ready sink.
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = n_starts;
      send(vecs[i].pt, vecs[i].key, vecs[i].id);
      check1("c1_in_ready", in_ready, 1'b0);
      check1("c1_busy", busy, 1'b1);
      check1("c1_aes_start", aes_start, 1'b0);
      step();
      check1("c2_aes_start", aes_start, 1'b1);
      checkv("c2_aes_state", aes_state, vecs[i].pt);
      step();
      check1("c3_aes_start", aes_start, 1'b0);
      check1("c3_in_ready", in_ready, 1'b1);
      wait_res(3, c);
      check_int("vec_latency", c, 29);
      checkv("vec_res_data", res_data, vecs[i].exp_ct);
      check_int("vec_res_id", int'(res_id), int'(vecs[i].id));
      step();
      check1("vec_res_cleared", res_valid, 1'b0);
      check_int("vec_done_cnt", int'(done_cnt), i + 1);
      check_int("vec_one_start", n_starts - s0, 1);
    end

    // Backpressure with a second request queued behind the first.
    do_reset();
    res_ready = 1'b0;
    send(vecs[3].pt, vecs[3].key, 4'd1);
    send(vecs[1].pt, vecs[1].key, 4'd2);
    wait_res(0, c);
    d = res_data; s0 = n_starts; saw = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (res_valid !== 1'b1 || res_data !== d || res_id !== 4'd1) saw++;
    end
    check_int("bp_stable", saw, 0);
    check_int("bp_no_new_start", n_starts - s0, 0);
    checkv("bp_res_data", res_data, vecs[3].exp_ct);
    check1("bp_in_ready_full", in_ready, 1'b0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check1("bp_hs_res_valid", res_valid, 1'b0);
    check1("bp_idle_no_start", aes_start, 1'b0);
    step();
    check1("bp_second_issue", aes_start, 1'b1);
    wait_res(2, c);
    check_int("bp_second_latency", c, 29);
    check_int("bp_second_id", int'(res_id), 2);
    checkv("bp_second_data", res_data, vecs[1].exp_ct);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_int("bp_done_cnt", int'(done_cnt), 2);

    // Stale out_valid from the previous job is high through IDLE and ISSUE.
    do_reset();
    res_ready = 1'b1;
    send(NIST_PT, NIST_KEY, 4'd9);
    wait_res(1, c);
    step();
    check1("stale_ov_present", aes_out_valid, 1'b1);
    send(vecs[2].pt, vecs[2].key, 4'd6);
    check1("stale_c1_res_valid", res_valid, 1'b0);
    step();
    check1("stale_c2_start", aes_start, 1'b1);
    check1("stale_c2_res_valid", res_valid, 1'b0);
    step();
    check1("stale_c3_ov", aes_out_valid, 1'b0);
    check1("stale_c3_res_valid", res_valid, 1'b0);
    wait_res(3, c);
    check_int("stale_latency", c, 29);
    checkv("stale_res_data", res_data, vecs[2].exp_ct);
    check_int("stale_res_id", int'(res_id), 6);

    // Watchdog: core never answers.
    do_reset();
    res_ready = 1'b1;
    never_valid = 1'b1;
    send(vecs[3].pt, vecs[3].key, 4'd3);
    c = 1; saw = 0;
    while (!err_timeout && c < 100) begin
      step(); c++;
      if (res_valid) saw = 1;
    end
    check_int("to_err_cycle", c, 2 + TIMEOUT + 1);
    check_int("to_no_result", saw, 0);
    check1("to_busy_idle", busy, 1'b0);
    never_valid = 1'b0;
    send(vecs[1].pt, vecs[1].key, 4'd4);
    wait_res(1, c);
    check_int("to_next_latency", c, 29);
    checkv("to_next_data", res_data, vecs[1].exp_ct);
    check_int("to_next_id", int'(res_id), 4);
    step();
    check_int("to_done_cnt", int'(done_cnt), 1);
    check1("to_err_sticky", err_timeout, 1'b1);

    // Reset at wait_cnt=10 (cycle 13) with non-reset state left over from above.
    send(vecs[2].pt, vecs[2].key, 4'd7);
    for (int k = 0; k < 12; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("mr_in_ready", in_ready, 1'b1);
    check1("mr_aes_start", aes_start, 1'b0);
    check1("mr_res_valid", res_valid, 1'b0);
    checkv("mr_res_data", res_data, 128'h0);
    checkv("mr_res_id", 128'(res_id), 128'h0);
    check1("mr_err_timeout", err_timeout, 1'b0);
    checkv("mr_done_cnt", 128'(done_cnt), 128'h0);
    check1("mr_busy", busy, 1'b0);
    s0 = n_starts; saw = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (res_valid) saw = 1;
    end
    check_int("mr_no_result", saw, 0);
    check_int("mr_no_start", n_starts - s0, 0);

    // Stream of four with a random sink.
    do_reset();
    s0 = n_starts;
    for (int i = 0; i < 4; i++) begin
      sp[i] = {4{32'(i) ^ 32'hA5A5_0000}};
      sk[i] = {6{32'h1000_0000 + 32'(i)}};
    end
    got = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(sp[i], sk[i], 4'(i));
      end
      begin
        int g = 0;
        logic rdy;
        while (got < 4 && g < 3000) begin
          rdy = 1'($urandom_range(0, 1));
          res_ready = rdy;
          if (res_valid && rdy) begin
            got_id[got] = res_id; got_dat[got] = res_data; got++;
          end
          @(posedge clk); #1;
          g++;
        end
        res_ready = 1'b0;
      end
    join
    check_int("st_count", got, 4);
    for (int i = 0; i < got; i++) begin
      check_int("st_id", int'(got_id[i]), i);
      checkv("st_data", got_dat[i], model_ct(sp[i], sk[i]));
    end
    check_int("st_starts", n_starts - s0, 4);
    check_int("st_done_cnt", int'(done_cnt), 4);
    check_int("start_single_cycle", bad_start, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
